// File: rtl/key_command_decoder.sv
// key_command_decoder: synchronizes and debounces two active-low push buttons,
// then drives a four-state stopwatch controller from the accepted presses.
`default_nettype none

module key_command_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic [1:0] KEY,
  output logic       run,
  output logic       clear,
  output logic       freeze,
  output logic [1:0] state,
  output logic [1:0] key_press
);

  localparam logic [1:0]  ST_IDLE    = 2'b00;
  localparam logic [1:0]  ST_RUNNING = 2'b01;
  localparam logic [1:0]  ST_STOPPED = 2'b10;
  localparam logic [1:0]  ST_LAP     = 2'b11;
  localparam logic [19:0] CNT_LAST   = 20'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       db_q, db_d;
  logic [1:0]       db_prev_q;
  logic [1:0][19:0] cnt_q, cnt_d;
  logic [1:0]       key_press_q, key_press_d;
  logic [1:0]       state_q, state_d;
  logic             clear_q, clear_d;

  // The level flips on the edge that would take the count to DEBOUNCE_CYCLES.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 20'd1;
        end
      end
    end
  end

  assign key_press_d = db_prev_q & ~db_q;

  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    if (key_press_d[0]) begin
      case (state_q)
        ST_IDLE:    state_d = ST_RUNNING;
        ST_RUNNING: state_d = ST_STOPPED;
        ST_STOPPED: state_d = ST_RUNNING;
        default:    state_d = ST_STOPPED;
      endcase
    end else if (key_press_d[1]) begin
      case (state_q)
        ST_RUNNING: state_d = ST_LAP;
        ST_LAP:     state_d = ST_RUNNING;
        default: begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      db_q        <= 2'b11;
      db_prev_q   <= 2'b11;
      cnt_q       <= '0;
      key_press_q <= 2'b00;
      state_q     <= ST_IDLE;
      clear_q     <= 1'b0;
    end else begin
      sync1_q     <= KEY;
      sync2_q     <= sync1_q;
      db_q        <= db_d;
      db_prev_q   <= db_q;
      cnt_q       <= cnt_d;
      key_press_q <= key_press_d;
      state_q     <= state_d;
      clear_q     <= clear_d;
    end
  end

  assign state     = state_q;
  assign key_press = key_press_q;
  assign clear     = clear_q;
  assign run       = (state_q == ST_RUNNING) || (state_q == ST_LAP);
  assign freeze    = (state_q == ST_LAP);

endmodule

`default_nettype wire

// File: tb/tb_key_command_decoder.sv
// Scoreboard bench for key_command_decoder with a short debounce window.
`default_nettype none

module tb_key_command_decoder;

  localparam int DEB = 4;

  logic       clk_50M = 1'b0;
  logic       reset   = 1'b1;
  logic [1:0] KEY     = 2'b11;
  logic       run, clear, freeze;
  logic [1:0] state, key_press;

  typedef struct packed {
    logic [1:0] kp;
    logic [1:0] st;
    logic       run;
    logic       frz;
    logic       clr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  key_command_decoder #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk_50M  (clk_50M),
    .reset    (reset),
    .KEY      (KEY),
    .run      (run),
    .clear    (clear),
    .freeze   (freeze),
    .state    (state),
    .key_press(key_press)
  );

  always #5 clk_50M = ~clk_50M;

  // Every key_press or clear cycle must match the next queued expectation.
  always @(negedge clk_50M) begin
    if (mon_en && (key_press !== 2'b00 || clear !== 1'b0)) begin
      exp_t obs;
      exp_t e;
      obs = '{kp: key_press, st: state, run: run, frz: freeze, clr: clear};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got kp=%b state=%b run=%b freeze=%b clear=%b, required no event",
                 key_press, state, run, freeze, clear);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          errors++;
          $display("FAIL scoreboard: got kp=%b state=%b run=%b freeze=%b clear=%b, required kp=%b state=%b run=%b freeze=%b clear=%b",
                   obs.kp, obs.st, obs.run, obs.frz, obs.clr, e.kp, e.st, e.run, e.frz, e.clr);
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  task automatic push_exp(input logic [1:0] kp, input logic [1:0] st,
                          input logic r, input logic f, input logic c);
    exp_q.push_back('{kp: kp, st: st, run: r, frz: f, clr: c});
  endtask

  task automatic do_reset(input logic [1:0] key_val);
    @(negedge clk_50M);
    reset = 1'b1;
    KEY   = key_val;
    wait_cycles(2);
    reset = 1'b0;
  endtask

  task automatic press(input int k);
    @(negedge clk_50M);
    KEY[k] = 1'b0;
    wait_cycles(12);
    KEY[k] = 1'b1;
    wait_cycles(12);
  endtask

  task automatic drain_check(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_events: got %0d pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    do_reset(2'b11);
    mon_en = 1'b1;
    checks++;
    if ({state, run, freeze, clear, key_press} !== 7'b0000000) begin
      errors++;
      $display("FAIL reset_outputs: got state=%b run=%b freeze=%b clear=%b kp=%b, required all zero",
               state, run, freeze, clear, key_press);
    end
    wait_cycles(10);
    checks++;
    if (state !== 2'b00 || run !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got state=%b run=%b, required 00/0", state, run);
    end
  endtask

  task automatic test_glitch();
    do_reset(2'b11);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_50M);
      KEY[k] = 1'b0;
      wait_cycles(DEB - 1);
      KEY[k] = 1'b1;
      wait_cycles(20);
    end
    checks++;
    if (state !== 2'b00) begin
      errors++;
      $display("FAIL glitch_state: got %b, required 00", state);
    end
    drain_check("glitch");
  endtask

  task automatic test_hold();
    int n;
    push_exp(2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
    do_reset(2'b10);
    n = 0;
    while (n < 50 && key_press === 2'b00) begin
      @(negedge clk_50M);
      n++;
    end
    checks++;
    if (n != DEB + 3) begin
      errors++;
      $display("FAIL hold_latency: got %0d cycles, required %0d", n, DEB + 3);
    end
    wait_cycles(30);
    checks++;
    if (state !== 2'b01 || run !== 1'b1) begin
      errors++;
      $display("FAIL hold_state: got state=%b run=%b, required 01/1", state, run);
    end
    KEY = 2'b11;
    wait_cycles(12);
    drain_check("hold");
  endtask

  task automatic test_lap();
    do_reset(2'b11);
    push_exp(2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
    press(0);
    push_exp(2'b10, 2'b11, 1'b1, 1'b1, 1'b0);
    press(1);
    checks++;
    if (freeze !== 1'b1 || run !== 1'b1) begin
      errors++;
      $display("FAIL lap_held: got freeze=%b run=%b, required 1/1", freeze, run);
    end
    push_exp(2'b10, 2'b01, 1'b1, 1'b0, 1'b0);
    press(1);
    push_exp(2'b01, 2'b10, 1'b0, 1'b0, 1'b0);
    press(0);
    push_exp(2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
    press(0);
    push_exp(2'b10, 2'b11, 1'b1, 1'b1, 1'b0);
    press(1);
    push_exp(2'b01, 2'b10, 1'b0, 1'b0, 1'b0);
    press(0);
    drain_check("lap");
  endtask

  task automatic test_stop_clear();
    do_reset(2'b11);
    push_exp(2'b10, 2'b00, 1'b0, 1'b0, 1'b1);
    press(1);
    push_exp(2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
    press(0);
    push_exp(2'b01, 2'b10, 1'b0, 1'b0, 1'b0);
    press(0);
    push_exp(2'b10, 2'b00, 1'b0, 1'b0, 1'b1);
    press(1);
    checks++;
    if (clear !== 1'b0 || run !== 1'b0 || state !== 2'b00) begin
      errors++;
      $display("FAIL stop_clear_after: got clear=%b run=%b state=%b, required 0/0/00", clear, run, state);
    end
    drain_check("stop_clear");
  endtask

  task automatic test_back_to_back();
    do_reset(2'b11);
    push_exp(2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
    press(0);
    push_exp(2'b11, 2'b10, 1'b0, 1'b0, 1'b0);
    @(negedge clk_50M);
    KEY = 2'b00;
    wait_cycles(12);
    KEY = 2'b11;
    wait_cycles(12);
    checks++;
    if (state !== 2'b10) begin
      errors++;
      $display("FAIL both_state: got %b, required 10", state);
    end
    drain_check("both");
  endtask

  task automatic test_reset_in_lap();
    do_reset(2'b11);
    push_exp(2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
    press(0);
    push_exp(2'b10, 2'b11, 1'b1, 1'b1, 1'b0);
    press(1);
    @(negedge clk_50M);
    reset = 1'b1;
    @(negedge clk_50M);
    reset = 1'b0;
    checks++;
    if ({state, run, freeze, clear} !== 5'b00000) begin
      errors++;
      $display("FAIL lap_reset: got state=%b run=%b freeze=%b clear=%b, required 00/0/0/0",
               state, run, freeze, clear);
    end
    drain_check("lap_reset");
  endtask

  task automatic test_reset_abort();
    do_reset(2'b11);
    @(negedge clk_50M);
    KEY = 2'b10;
    wait_cycles(DEB);
    push_exp(2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk_50M);
    reset = 1'b0;
    wait_cycles(20);
    KEY = 2'b11;
    wait_cycles(12);
    drain_check("reset_abort");
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_hold();
    test_lap();
    test_stop_clear();
    test_back_to_back();
    test_reset_in_lap();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/key_command_decoder.md
KEY_COMMAND_DECODER -- requirements
Module: key_command_decoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, consecutive clk_50M cycles a key level must hold before acceptance (10 ms at 50 MHz); legal range 2..1048575.
REQ-002 clk_50M  input  1  system clock; all state SHALL change only on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on the clk_50M rising edge.
REQ-004 KEY  input  2  raw push buttons, active-low, asynchronous to clk_50M; KEY[0] = start/stop, KEY[1] = lap/clear.
REQ-005 run  output  1  counter enable; high while the stopwatch is counting.
REQ-006 clear  output  1  one-cycle pulse commanding the counters to zero.
REQ-007 freeze  output  1  high while the display holds a lap value; counting continues underneath.
REQ-008 state  output  2  current FSM state encoding: IDLE=00, RUNNING=01, STOPPED=10, LAP=11.
REQ-009 key_press  output  2  one-cycle pulse per accepted press, bit-aligned with KEY.

Function
REQ-010 Each KEY bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Each key SHALL have an independent debounced level and a 20-bit stability counter.
REQ-012 Counter behaviour: cleared on any cycle where synchronized level equals debounced level; incremented while they differ.
REQ-013 The debounced level SHALL take the synchronized value on the edge where the counter would reach DEBOUNCE_CYCLES; the counter clears on that same edge.
REQ-014 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no debounced change and no key_press.
REQ-015 key_press[i] SHALL be high for exactly one cycle, the cycle after debounced level i goes 1->0; release (0->1) produces no pulse.
REQ-016 A held key SHALL produce exactly one key_press until released and re-pressed.
REQ-017 FSM transitions on key_press[0]: IDLE->RUNNING, RUNNING->STOPPED, STOPPED->RUNNING, LAP->STOPPED.
REQ-018 FSM transitions on key_press[1]: RUNNING->LAP, LAP->RUNNING, STOPPED->IDLE, IDLE->IDLE.
REQ-019 Any key_press[1] taken from STOPPED or IDLE SHALL assert clear for one cycle, coincident with the state update.
REQ-020 State, run, freeze and clear SHALL update on the same edge at which key_press is first visible high (one registered stage after the debounce flip).
REQ-021 Output decode: run=1 in RUNNING and LAP, else 0; freeze=1 only in LAP.
REQ-022 If key_press[0] and key_press[1] occur in the same cycle, key_press[0] SHALL win and key_press[1] is discarded; both key_press bits still pulse.
REQ-023 Counters SHALL saturate-free wrap is impossible: DEBOUNCE_CYCLES < 2^20 bounds the count.
REQ-024 No combinational path from KEY to any output.

Reset
REQ-025 On reset=1 at a clock edge: synchronizers and debounced levels = 1 (released), stability counters = 0, state = IDLE.
REQ-026 During and after reset: run=0, freeze=0, clear=0, key_press=00.
REQ-027 Reset asserted mid-debounce or in any state SHALL abort in-progress acceptance; a key held low through reset deassertion SHALL be accepted as a new press after DEBOUNCE_CYCLES+2 cycles.
REQ-028 Reset SHALL take priority over every key event in the same cycle.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 KEY[0] low for 3 cycles then high -> no key_press, state stays 00.
REQ-030 KEY[0] held low from reset release -> key_press[0] one cycle, state 00->01, run=1; no second pulse while held.
REQ-031 Press KEY[0], KEY[1], KEY[1] -> states 01, 11 (freeze=1, run=1), 01 (freeze=0).
REQ-032 From RUNNING press KEY[0] then KEY[1] -> state 10 then 00, clear=1 for exactly one cycle, run=0.
REQ-033 KEY[1:0] fall on the same cycle while in RUNNING -> both key_press bits pulse, state 10, clear=0.
REQ-034 State LAP, reset pulsed one cycle -> next cycle state=00, run=0, freeze=0, clear=0.
